// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command initiator.
// State encoding, default abort window and response flag layout.
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam int RSP_ERR_BIT = 0;
    localparam int RSP_TMO_BIT = 1;
    localparam int RSP_FLAGS_W = 2;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear.
// Expires while enabled on the cycle the count reaches TIMEOUT-1.
module wb_timeout_counter
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one bus cycle per accepted command,
// result returned on a registered response port.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [31:0]       cmd_dat_i,
    input  logic [3:0]        cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    input  logic [31:0]       wbm_dat_i
);

    state_e state, state_d;

    logic                   accept;
    logic                   bus_done;
    logic                   rsp_pop;
    logic                   expire;
    logic [31:0]            dat_d;
    logic [RSP_FLAGS_W-1:0] flags_d;
    logic [RSP_FLAGS_W-1:0] rsp_flags;

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .clear  (accept),
        .enable (state == BUS),
        .expire (expire)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Completion priority: ack, then err, then watchdog expiry.
    always_comb begin
        state_d  = state;
        accept   = 1'b0;
        bus_done = 1'b0;
        rsp_pop  = 1'b0;
        dat_d    = '0;
        flags_d  = '0;
        unique case (state)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    bus_done = 1'b1;
                    dat_d    = wbm_we_o ? 32'd0 : wbm_dat_i;
                end else if (wbm_err_i) begin
                    bus_done             = 1'b1;
                    flags_d[RSP_ERR_BIT] = 1'b1;
                end else if (expire) begin
                    bus_done             = 1'b1;
                    flags_d[RSP_ERR_BIT] = 1'b1;
                    flags_d[RSP_TMO_BIT] = 1'b1;
                end
                if (bus_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_pop = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_flags   <= '0;
        end else begin
            cmd_ready_o <= (state_d == IDLE);
            if (accept) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
                wbm_sel_o <= cmd_sel_i;
            end
            if (bus_done) begin
                wbm_cyc_o   <= 1'b0;
                wbm_stb_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_dat_o   <= dat_d;
                rsp_flags   <= flags_d;
            end
            if (rsp_pop) begin
                rsp_valid_o <= 1'b0;
                rsp_dat_o   <= '0;
                rsp_flags   <= '0;
            end
        end
    end

    assign rsp_err_o     = rsp_flags[RSP_ERR_BIT];
    assign rsp_timeout_o = rsp_flags[RSP_TMO_BIT];

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a scripted Wishbone slave.
// Cycle numbers count rising edges after the command accept edge.
module tb_wb_cmd_master;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          mode;
        int          waits;
        logic [31:0] rdata;
        int          exp_stb;
        int          exp_rsp;
        logic [31:0] exp_dat;
        logic        exp_err;
        logic        exp_tmo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_tmo;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        ack, err;
    logic [31:0] s_rdata = '0;
    int          s_mode = M_NONE;
    int          s_waits = 0;
    int          wcnt = 0;
    logic        stray = 1'b0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) wcnt <= stb ? wcnt + 1 : 0;

    assign ack = stray | (stb && (s_mode == M_ACK || s_mode == M_BOTH)
                          && wcnt == s_waits);
    assign err = stray | (stb && (s_mode == M_ERR || s_mode == M_BOTH)
                          && wcnt == s_waits);

    wb_cmd_master #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_adr_i     (cmd_adr),
        .cmd_dat_i     (cmd_dat),
        .cmd_sel_i     (cmd_sel),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_dat_o     (rsp_dat),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_tmo),
        .wbm_cyc_o     (cyc),
        .wbm_stb_o     (stb),
        .wbm_we_o      (we),
        .wbm_adr_o     (adr),
        .wbm_dat_o     (wdat),
        .wbm_sel_o     (sel),
        .wbm_ack_i     (ack),
        .wbm_err_i     (err),
        .wbm_dat_i     (s_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Waits (bounded) for cmd_ready at a falling edge, then crosses
    // the accept edge and lands on the cycle-1 falling edge.
    task automatic accept_cmd(output bit ok);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready;
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit ok;
        int stb_cnt = 0;
        int rsp_cyc = 0;
        int bad = 0;
        @(negedge clk);
        s_mode    = v.mode;
        s_waits   = v.waits;
        s_rdata   = v.rdata;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        cmd_valid = 1'b1;
        accept_cmd(ok);
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_accept", idx), 64'(ok), 64'd1);
        for (int c = 1; c < 30; c++) begin
            if (stb) begin
                stb_cnt++;
                if (!cyc || we !== v.we || adr !== v.adr
                    || wdat !== v.dat || sel !== v.sel) bad++;
            end
            if (rsp_valid) begin
                rsp_cyc = c;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_bus_fields", idx), 64'(bad), 64'd0);
        chk($sformatf("v%0d_stb_cycles", idx), 64'(stb_cnt), 64'(v.exp_stb));
        chk($sformatf("v%0d_rsp_cycle", idx), 64'(rsp_cyc), 64'(v.exp_rsp));
        chk($sformatf("v%0d_rsp", idx),
            {29'd0, rsp_err, rsp_tmo, cyc, rsp_dat},
            {29'd0, v.exp_err, v.exp_tmo, 1'b0, v.exp_dat});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_pop", idx), {62'd0, rsp_valid, cmd_ready},
            64'd1);
    endtask

    vec_t vecs[8];

    initial begin
        bit ok;
        int bad;
        logic [31:0] held;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int bad;

        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, M_ACK, 0,
                    32'h5555_AAAA, 1, 2, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h3000_0000, 32'h0, 4'hF, M_ACK, 3,
                    32'h1234_5678, 4, 5, 32'h1234_5678, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h3000_0008, 32'h0, 4'hF, M_NONE, 0,
                    32'h7777_7777, 4, 5, 32'h0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 32'h3000_000C, 32'h0, 4'h3, M_BOTH, 1,
                    32'hA5A5_0001, 2, 3, 32'hA5A5_0001, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h3000_0010, 32'h0, 4'hF, M_ERR, 0,
                    32'h0000_FFFF, 1, 2, 32'h0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h4000_0000, 32'h0102_0304, 4'h1, M_ERR, 2,
                    32'h0, 3, 4, 32'h0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h4000_0004, 32'hFEED_FACE, 4'hC, M_BOTH, 0,
                    32'h9999_9999, 1, 2, 32'h0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_1000, 32'h0, 4'h3, M_ACK, 0,
                    32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {cmd_ready, rsp_valid, rsp_err, rsp_tmo, cyc, stb, we},
            64'd0);
        chk("reset_data", {rsp_dat, adr}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(cmd_ready), 64'd1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Strobes outside a bus cycle must not produce a response.
        @(negedge clk);
        stray = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || cyc || !cmd_ready) bad++;
        end
        stray = 1'b0;
        chk("stray_ack_ignored", 64'(bad), 64'd0);

        // Response back-pressure with a second command waiting.
        @(negedge clk);
        s_mode    = M_ACK;
        s_waits   = 0;
        s_rdata   = 32'h0BAD_F00D;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h2000_0010;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        accept_cmd(ok);
        chk("bp_accept", 64'(ok), 64'd1);
        cmd_we  = 1'b1;
        cmd_adr = 32'h2000_0020;
        cmd_dat = 32'h1111_2222;
        @(negedge clk);
        chk("bp_rsp_cycle2", {rsp_valid, rsp_dat}, {1'b1, 32'h0BAD_F00D});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_dat !== 32'h0BAD_F00D || rsp_err
                || cmd_ready || cyc) bad++;
            @(negedge clk);
        end
        chk("bp_hold_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_after_pop", {rsp_valid, cmd_ready, cyc}, 64'b010);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_cmd", {cyc, stb, we, adr, wdat},
            {3'b111, 32'h2000_0020, 32'h1111_2222});
        @(negedge clk);
        chk("bp_second_rsp", {rsp_valid, rsp_err, rsp_dat},
            {2'b10, 32'h0});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of a bus cycle.
        s_mode    = M_NONE;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h5000_0000;
        cmd_valid = 1'b1;
        accept_cmd(ok);
        cmd_valid = 1'b0;
        chk("rst_accept", 64'(ok), 64'd1);
        @(negedge clk);
        chk("rst_stb_before", {cyc, stb}, 64'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {cyc, stb, rsp_valid, cmd_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_low", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("rst_ready_high", 64'(cmd_ready), 64'd1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || cyc || stb) bad++;
        end
        chk("rst_no_response", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic initiator that turns single read/write commands from a simple valid/ready port into one Wishbone bus cycle each, then returns the read data and error status on a response port. It sits on the initiator side of the same bus our wrapped projects respond on. It lets a test harness or on-chip sequencer drive any wrapped design's wishbone slave port. A per-cycle timeout stops the bus from hanging on a slave that never acknowledges.

## Interface
- TIMEOUT, 255: cycles with stb high and no ack/err before the cycle aborts; legal range 1..65535.
- ADDR_W, 32: address width.
- wb_clk_i  in  1  bus clock; every register is clocked on its rising edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_W  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte lane selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid & ready.
- rsp_dat_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  slave err or timeout.
- rsp_timeout_o  out  1  error was a timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls.
- wbm_adr_o  out  ADDR_W; wbm_dat_o  out  32; wbm_sel_o  out  4.
- wbm_ack_i, wbm_err_i  in  1; wbm_dat_i  in  32.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: cmd_ready_o=1. On accept, register we/adr/dat/sel into the wbm_* outputs, set cyc=stb=1, clear the timeout counter, go to BUS.
- BUS: cmd_ready_o=0. The counter increments every cycle.
  - ack_i=1: capture dat_i (reads only; writes return 0), err=0, go to RESP.
  - err_i=1 (and no ack): err=1, timeout=0, dat=0, go to RESP.
  - Counter reaches TIMEOUT-1 with neither: err=1, timeout=1, dat=0, go to RESP.
  - Priority when events coincide: ack > err > timeout.
  - Leaving BUS: cyc and stb drop on the same edge that rsp_valid rises.
- RESP: rsp_valid_o=1 and held stable until rsp_ready_i. Then go to IDLE.
  - No command is accepted in the RESP cycle. A command accepted in IDLE is the earliest possible.
- Single outstanding transaction. Commands never pipeline.
- ack_i/err_i outside BUS are ignored.
- Reset: state=IDLE. All outputs are 0 except cmd_ready_o, which is 0 during reset and 1 from the first clock edge after deassertion.
  - Reset asserted mid-cycle drops cyc/stb immediately (asynchronously). The pending response is discarded.
- wbm_adr/dat/sel/we are held constant for the whole BUS state.

## Timing
- Cycle 0: accept edge. From cycle 1: cyc/stb high.
- A slave that acks in the first cycle stb is high gives rsp_valid on cycle 2.
- Minimum command-to-command spacing is 3 cycles (accept, BUS, RESP with rsp_ready=1). The next command is accepted on cycle 3.
- Timeout: stb stays high for exactly TIMEOUT cycles. rsp_valid rises on the following edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package wb_cmd_master_pkg holds:
  - the state enum (IDLE/BUS/RESP, 2 bits);
  - the default TIMEOUT constant;
  - the response-flag bit positions.
- Sub-module wb_timeout_counter, 16 bits:
  - inputs: clear and enable;
  - output: an expire pulse when the count equals TIMEOUT-1.

## Test plan
- Write adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF; slave acks in 1 cycle. Required:
  - cyc/stb/we high for exactly one cycle with matching adr/dat/sel;
  - rsp_err=0 and rsp_dat=0 on cycle 2.
- Read adr=0x3000_0000; slave returns 0x1234_5678 with ack after 3 wait cycles. Required: rsp_dat=0x12345678, err=0, rsp_valid on cycle 5.
- Silent slave, TIMEOUT=4. Required: stb high for exactly 4 cycles, then rsp_err=1, rsp_timeout=1, rsp_dat=0, cyc low.
- ack and err asserted in the same cycle. Required: rsp_err=0, data captured. Separately, err alone gives err=1, timeout=0.
- rsp_ready held low for 10 cycles with a back-to-back command pending. Required:
  - rsp_valid and rsp_dat stay stable;
  - cmd_ready stays 0;
  - the second command is accepted only after the response handshake.
- Reset pulsed low during BUS. Required: cyc/stb low before the next clock edge, no response emitted, cmd_ready=1 one edge after release.
